led_scan_driver: RTL and testbench
==================================

Name: led_scan_driver

Overview:
- Upstream feeder for the octal inverting LED buffer stage: drives its eight data inputs and the bank-select lines of a multiplexed LED matrix.
- Holds BANKS 8-bit display registers, loaded from the CPU data bus.
- Time-multiplexes the registers onto a single 8-bit LED data port, with a one-cycle dead slot between banks to prevent ghosting.
- Output data is active-high; the downstream inverting buffer turns it into low-side LED sink drive.

Parameters:
- BANKS, 4, number of display registers / LED banks; legal range 2..8.
- PRESCALE, 1024, clock cycles each bank is shown per visit; legal range 2..65535.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- bus_data  input  8  value to store in a display register.
- load_en  input  1  write strobe, sampled on rising clk.
- load_sel  input  3  target register index.
- blank  input  1  forces the display dark; scanning continues.
- led_data  output  8  active-high LED data to the inverting buffer inputs.
- bank_sel_n  output  BANKS  one-cold bank enable; all-ones means no bank driven.
- frame_start  output  1  one-cycle pulse when bank 0 becomes active.

Behaviour:
- Reset is asynchronous, active-low: clk and rst_n as named; asynchronous assertion, release takes effect on the next rising clk.
- Reset values while rst_n=0:
  - all display registers 0x00
  - state=DEAD, idx=0, cnt=0
  - led_data=0x00, bank_sel_n=all ones, frame_start=0
- State machine, two states:
  - DEAD: exactly one cycle; next state SHOW; cnt=0.
  - SHOW: cnt increments each cycle. When cnt==PRESCALE-1: cnt<=0, idx<=(idx==BANKS-1)?0:idx+1, state<=DEAD.
- Timing:
  - Each bank occupies PRESCALE SHOW cycles plus 1 DEAD cycle.
  - Frame period = BANKS*(PRESCALE+1) cycles.
  - First rising edge after reset release enters SHOW with idx=0.
- Outputs are decoded from registered state only (no input-to-output combinational path except through registers).
  - SHOW, blank=0: bank_sel_n = all ones with bit idx cleared; led_data = reg[idx].
  - DEAD, or blank=1: bank_sel_n = all ones; led_data = 0x00.
- frame_start is registered: high for exactly the first SHOW cycle of idx=0, including the first SHOW after reset.
- Loads:
  - load_en=1 with load_sel<BANKS: reg[load_sel]<=bus_data on the rising edge.
  - A write to the currently shown bank appears on led_data in the following cycle.
  - load_sel>=BANKS: write ignored, no other effect.
- Simultaneous events:
  - Load and bank advance on the same edge: write completes; the new value is shown whenever that bank is next displayed.
  - Load during DEAD or blank: stored normally.
- blank does not stall cnt/idx; deasserting blank mid-slot restores the display on the next cycle.
- Reset mid-frame: immediate return to reset values; display registers are cleared.
- The downstream buffer's output enables are tied active in the board netlist. Blanking is done only by zeroing led_data and deasserting bank_sel_n, never via buffer OE.

Test Plan (BANKS=4, PRESCALE=4):
1. Reset release, no loads -> bank_sel_n sequence 1110×4, 1111×1, 1101×4, 1111, 1011×4, 1111, 0111×4, 1111, then repeat; led_data 0x00 throughout; frame_start pulses every 20 cycles, first pulse on the first edge after release.
2. Load reg0=0xA5, reg1=0x3C, reg2=0xFF, reg3=0x01 while idx=0 -> over the next frame, led_data shows 0xA5/0x3C/0xFF/0x01 in the matching SHOW slots and 0x00 in every DEAD cycle.
3. Write 0x81 to reg[idx] during SHOW cycle 2 of that bank -> led_data changes to 0x81 on cycle 3; other banks unchanged.
4. load_sel=5, bus_data=0xEE, load_en=1 -> no register changes; displayed sequence identical to the prior frame.
5. blank=1 for 7 cycles starting mid-slot of bank 1 -> bank_sel_n=1111 and led_data=0x00 during those cycles; after deassert, output resumes at exactly the idx/cnt position it would have reached without blanking.
6. rst_n pulled low in bank 2, SHOW cycle 1, with reg2=0xFF -> outputs go to 0x00/1111 immediately without waiting for clk; after release, registers read back 0x00 and scanning restarts at bank 0 with frame_start=1.

Source files
------------

// File: rtl/led_scan_driver.sv
// Multiplexed LED bank scanner: BANKS display registers shown one bank at a time,
// with a one-cycle dead slot between banks. Outputs are decoded from registers only.
module led_scan_driver #(
  parameter int BANKS    = 4,
  parameter int PRESCALE = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       bus_data,
  input  logic             load_en,
  input  logic [2:0]       load_sel,
  input  logic             blank,
  output logic [7:0]       led_data,
  output logic [BANKS-1:0] bank_sel_n,
  output logic             frame_start
);
  localparam int IW = (BANKS > 1) ? $clog2(BANKS) : 1;

  typedef enum logic {DEAD, SHOW} state_t;

  state_t        r_state;
  logic [IW-1:0] r_idx;
  logic [15:0]   r_cnt;
  logic          r_blank;
  logic          r_frame_start;
  logic [7:0]    r_disp [BANKS];
  logic          w_on;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= DEAD;
      r_idx         <= '0;
      r_cnt         <= '0;
      r_blank       <= 1'b0;
      r_frame_start <= 1'b0;
      for (int b = 0; b < BANKS; b++) r_disp[b] <= 8'h00;
    end else begin
      r_blank <= blank;
      // Selects at or above BANKS match no register and are dropped.
      for (int b = 0; b < BANKS; b++)
        if (load_en && load_sel == 3'(b)) r_disp[b] <= bus_data;
      case (r_state)
        DEAD: begin
          r_state       <= SHOW;
          r_cnt         <= '0;
          r_frame_start <= (r_idx == '0);
        end
        SHOW: begin
          r_frame_start <= 1'b0;
          if (r_cnt == 16'(PRESCALE - 1)) begin
            r_cnt   <= '0;
            r_idx   <= (r_idx == IW'(BANKS - 1)) ? '0 : r_idx + 1'b1;
            r_state <= DEAD;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: r_state <= DEAD;
      endcase
    end
  end

  // Blank goes through r_blank so no input reaches the pins combinationally.
  assign w_on        = (r_state == SHOW) && !r_blank;
  assign bank_sel_n  = w_on ? ~(BANKS'(1) << r_idx) : '1;
  assign led_data    = w_on ? r_disp[r_idx] : 8'h00;
  assign frame_start = r_frame_start;
endmodule

// File: tb/tb_led_scan_driver.sv
// Directed bench for led_scan_driver (BANKS=4, PRESCALE=4) using a frame-position
// reference model and an expected-output queue.
module tb_led_scan_driver;
  localparam int BANKS = 4, PRESCALE = 4, FRAME = BANKS * (PRESCALE + 1);

  logic       clk = 1'b0, rst_n = 1'b0;
  logic [7:0] bus_data = 8'h00;
  logic       load_en = 1'b0, blank = 1'b0;
  logic [2:0] load_sel = 3'd0;
  logic [7:0] led_data;
  logic [3:0] bank_sel_n;
  logic       frame_start;

  led_scan_driver #(.BANKS(BANKS), .PRESCALE(PRESCALE)) dut (
    .clk(clk), .rst_n(rst_n), .bus_data(bus_data), .load_en(load_en),
    .load_sel(load_sel), .blank(blank), .led_data(led_data),
    .bank_sel_n(bank_sel_n), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [7:0] led;
    logic [3:0] sel;
    logic       fs;
  } exp_t;

  exp_t       sb [$];
  int         checks = 0, passed = 0;
  int         t = -1;          // edges since reset release, -1 while in reset
  logic [7:0] mreg [8];
  logic       mblank = 1'b0;

  function automatic exp_t predict(string tag);
    exp_t e;
    int pos, bank, slot;
    e.tag = tag;
    if (t < 0) begin
      e.led = 8'h00; e.sel = 4'hF; e.fs = 1'b0;
    end else begin
      pos  = t % FRAME;
      bank = pos / (PRESCALE + 1);
      slot = pos % (PRESCALE + 1);
      if (slot < PRESCALE && !mblank) begin
        e.sel = 4'hF & ~(4'b0001 << bank);
        e.led = mreg[bank];
      end else begin
        e.sel = 4'hF;
        e.led = 8'h00;
      end
      e.fs = (pos == 0);
    end
    return e;
  endfunction

  task automatic check_one(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
  endtask

  task automatic compare_head();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      $error("FAIL scoreboard_empty t=%0d", t);
      return;
    end
    e = sb.pop_front();
    check_one({e.tag, "_led"}, led_data, e.led);
    check_one({e.tag, "_sel"}, {4'h0, bank_sel_n}, {4'h0, e.sel});
    check_one({e.tag, "_fs"},  {7'h0, frame_start}, {7'h0, e.fs});
  endtask

  // One clock: update the reference at the edge, queue its prediction, compare #1 later.
  task automatic cyc(string tag);
    @(posedge clk);
    if (!rst_n) begin
      t = -1; mblank = 1'b0;
      for (int i = 0; i < 8; i++) mreg[i] = 8'h00;
    end else begin
      t++;
      if (load_en && load_sel < BANKS) mreg[load_sel] = bus_data;
      mblank = blank;
    end
    sb.push_back(predict(tag));
    #1;
    compare_head();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mreg[i] = 8'h00;
    // Reset state
    #2;
    sb.push_back(predict("reset"));
    compare_head();
    cyc("reset_hold");
    cyc("reset_hold");
    rst_n = 1'b1;

    // 1: free-running scan, two frames, all dark data
    for (int i = 0; i < 2 * FRAME; i++) cyc("scan_idle");

    // 2: load all four banks
    bus_data = 8'hA5; load_sel = 3'd0; load_en = 1'b1; cyc("load0");
    bus_data = 8'h3C; load_sel = 3'd1; cyc("load1");
    bus_data = 8'hFF; load_sel = 3'd2; cyc("load2");
    bus_data = 8'h01; load_sel = 3'd3; cyc("load3");
    load_en = 1'b0;
    for (int i = 0; i < FRAME + 4; i++) cyc("scan_data");

    // 3: overwrite bank 1 on the edge ending its second SHOW cycle
    while ((t % FRAME) != 6) cyc("seek_live");
    bus_data = 8'h81; load_sel = 3'd1; load_en = 1'b1;
    cyc("live_write");
    load_en = 1'b0;
    for (int i = 0; i < FRAME; i++) cyc("after_live");

    // 4: out-of-range select is ignored
    bus_data = 8'hEE; load_sel = 3'd5; load_en = 1'b1;
    cyc("bad_sel");
    load_en = 1'b0;
    for (int i = 0; i < FRAME; i++) cyc("after_bad_sel");

    // 5: blank for 7 cycles starting mid-slot of bank 1
    while ((t % FRAME) != 7) cyc("seek_blank");
    blank = 1'b1;
    for (int i = 0; i < 7; i++) cyc("blank");
    blank = 1'b0;
    for (int i = 0; i < 15; i++) cyc("unblank");

    // 6: asynchronous reset during bank 2 SHOW cycle 1
    while ((t % FRAME) != 10) cyc("seek_reset");
    rst_n = 1'b0;
    t = -1;
    for (int i = 0; i < 8; i++) mreg[i] = 8'h00;
    mblank = 1'b0;
    #1;
    sb.push_back(predict("async_reset"));
    compare_head();
    cyc("reset_mid");
    cyc("reset_mid");
    rst_n = 1'b1;
    for (int i = 0; i < FRAME + 5; i++) cyc("post_reset");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
